// File: rtl/buyruk_onbellek_denetleyici_p_pkg.sv
// rtl/buyruk_onbellek_denetleyici_p_pkg.sv - shared states, default widths and log2 helper for the instruction cache
package buyruk_onbellek_paket;

    localparam int VARSAYILAN_ADRES_BIT    = 32;
    localparam int VARSAYILAN_VERI_BIT     = 32;
    localparam int VARSAYILAN_BLOK_BIT     = 128;
    localparam int VARSAYILAN_SATIR_SAYISI = 256;
    localparam int VARSAYILAN_SAYAC_BIT    = 32;

    typedef enum logic [2:0] {
        BOSTA           = 3'd0,
        KARSILASTIR     = 3'd1,
        ANABELLEK_ISTE  = 3'd2,
        ANABELLEK_BEKLE = 3'd3,
        CEVAPLA         = 3'd4,
        TEMIZLE         = 3'd5
    } durum_t;

    // Ceiling log2; arguments are powers of two so this is exact.
    function automatic int log2_al(input int deger);
        int sonuc;
        sonuc = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < deger) begin
                sonuc = i + 1;
            end
        end
        return sonuc;
    endfunction

endpackage

// File: rtl/buyruk_onbellek_denetleyici_p_dizisi.sv
// rtl/buyruk_onbellek_denetleyici_p_dizisi.sv - tag/data arrays with a flat valid vector
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset (valid bits only)
//   okuma_i / okuma_satir_i         synchronous read strobe and line index
//   okuma_etiket/blok/gecerli_o     registered read results
//   yazma_i / yazma_satir/etiket/blok_i  single write port; also sets the line valid
//   gecersizle_i                    clears every valid bit in one cycle
module buyruk_onbellek_dizisi
    import buyruk_onbellek_paket::*;
#(
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
    parameter int SATIR_BIT    = 8,
    parameter int ETIKET_BIT   = 20,
    parameter int BLOK_BIT     = VARSAYILAN_BLOK_BIT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  okuma_i,
    input  logic [SATIR_BIT-1:0]  okuma_satir_i,
    output logic [ETIKET_BIT-1:0] okuma_etiket_o,
    output logic [BLOK_BIT-1:0]   okuma_blok_o,
    output logic                  okuma_gecerli_o,
    input  logic                  yazma_i,
    input  logic [SATIR_BIT-1:0]  yazma_satir_i,
    input  logic [ETIKET_BIT-1:0] yazma_etiket_i,
    input  logic [BLOK_BIT-1:0]   yazma_blok_i,
    input  logic                  gecersizle_i
);

    logic [ETIKET_BIT-1:0]   etiket_dizi [SATIR_SAYISI];
    logic [BLOK_BIT-1:0]     veri_dizi   [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0] gecerli_q;

    // Storage arrays carry no reset so they map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (yazma_i) begin
            etiket_dizi[yazma_satir_i] <= yazma_etiket_i;
            veri_dizi[yazma_satir_i]   <= yazma_blok_i;
        end
        if (okuma_i) begin
            okuma_etiket_o <= etiket_dizi[okuma_satir_i];
            okuma_blok_o   <= veri_dizi[okuma_satir_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_q       <= '0;
            okuma_gecerli_o <= 1'b0;
        end else begin
            if (gecersizle_i) begin
                gecerli_q <= '0;
            end else if (yazma_i) begin
                gecerli_q[yazma_satir_i] <= 1'b1;
            end
            if (okuma_i) begin
                okuma_gecerli_o <= gecerli_q[okuma_satir_i];
            end
        end
    end

endmodule

// File: rtl/buyruk_onbellek_denetleyici_p.sv
// rtl/buyruk_onbellek_denetleyici_p.sv - direct-mapped instruction cache controller
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   getir_istek_*                        fetch request (address, valid, ready)
//   getir_buyruk_o / _gecerli_o          instruction and its one-cycle valid pulse
//   temizle_i                            flush (fence.i) pulse
//   anabellek_okuma_istek_*              line refill request towards main memory
//   anabellek_okuma_veri_blok_i/_gecerli_i  refill line return
//   isabet_sayac_o / iska_sayac_o        saturating hit / miss counters
module buyruk_onbellek_denetleyici_p
    import buyruk_onbellek_paket::*;
#(
    parameter int ADRES_BIT    = VARSAYILAN_ADRES_BIT,
    parameter int VERI_BIT     = VARSAYILAN_VERI_BIT,
    parameter int BLOK_BIT     = VARSAYILAN_BLOK_BIT,
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
    parameter int SAYAC_BIT    = VARSAYILAN_SAYAC_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] getir_istek_adres_i,
    input  logic                 getir_istek_gecerli_i,
    output logic                 getir_istek_hazir_o,
    output logic [VERI_BIT-1:0]  getir_buyruk_o,
    output logic                 getir_buyruk_gecerli_o,
    input  logic                 temizle_i,
    output logic [ADRES_BIT-1:0] anabellek_okuma_istek_adres_o,
    output logic                 anabellek_okuma_istek_gecerli_o,
    input  logic                 anabellek_okuma_istek_hazir_i,
    input  logic [BLOK_BIT-1:0]  anabellek_okuma_veri_blok_i,
    input  logic                 anabellek_okuma_veri_gecerli_i,
    output logic [SAYAC_BIT-1:0] isabet_sayac_o,
    output logic [SAYAC_BIT-1:0] iska_sayac_o
);

    localparam int BAYT_BIT      = log2_al(BLOK_BIT / 8);
    localparam int SATIR_BIT     = log2_al(SATIR_SAYISI);
    localparam int ETIKET_BIT    = ADRES_BIT - SATIR_BIT - BAYT_BIT;
    localparam int KELIME_SAYISI = BLOK_BIT / VERI_BIT;

    durum_t durum_q, durum_d;

    logic [ADRES_BIT-1:0] adres_q;
    logic [BLOK_BIT-1:0]  blok_q;
    logic                 temizle_bekliyor_q;

    logic [ETIKET_BIT-1:0] okuma_etiket;
    logic [BLOK_BIT-1:0]   okuma_blok;
    logic                  okuma_gecerli;
    logic                  yazma;
    logic                  gecersizle;
    logic                  kabul;
    logic                  isabet;

    logic [KELIME_SAYISI-1:0][VERI_BIT-1:0] okuma_kelimeleri;
    logic [KELIME_SAYISI-1:0][VERI_BIT-1:0] blok_kelimeleri;
    logic [BAYT_BIT-3:0]                    kelime_sec;

    logic unused_adres_bitleri;
    assign unused_adres_bitleri = ^adres_q[1:0];

    assign okuma_kelimeleri = okuma_blok;
    assign blok_kelimeleri  = blok_q;
    assign kelime_sec       = adres_q[BAYT_BIT-1:2];

    assign isabet = okuma_gecerli && (okuma_etiket == adres_q[ADRES_BIT-1 -: ETIKET_BIT]);
    assign kabul  = getir_istek_gecerli_i && getir_istek_hazir_o;

    assign anabellek_okuma_istek_adres_o = {adres_q[ADRES_BIT-1:BAYT_BIT], {BAYT_BIT{1'b0}}};

    buyruk_onbellek_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI),
        .SATIR_BIT    (SATIR_BIT),
        .ETIKET_BIT   (ETIKET_BIT),
        .BLOK_BIT     (BLOK_BIT)
    ) u_dizi (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .okuma_i         (kabul),
        .okuma_satir_i   (getir_istek_adres_i[BAYT_BIT +: SATIR_BIT]),
        .okuma_etiket_o  (okuma_etiket),
        .okuma_blok_o    (okuma_blok),
        .okuma_gecerli_o (okuma_gecerli),
        .yazma_i         (yazma),
        .yazma_satir_i   (adres_q[BAYT_BIT +: SATIR_BIT]),
        .yazma_etiket_i  (adres_q[ADRES_BIT-1 -: ETIKET_BIT]),
        .yazma_blok_i    (anabellek_okuma_veri_blok_i),
        .gecersizle_i    (gecersizle)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q            <= BOSTA;
            adres_q            <= '0;
            blok_q             <= '0;
            temizle_bekliyor_q <= 1'b0;
            isabet_sayac_o     <= '0;
            iska_sayac_o       <= '0;
        end else begin
            durum_q <= durum_d;
            if (kabul) begin
                adres_q <= getir_istek_adres_i;
            end
            if (yazma) begin
                blok_q <= anabellek_okuma_veri_blok_i;
            end
            // A pulse arriving during TEMIZLE re-arms the flag for another pass.
            if (temizle_i) begin
                temizle_bekliyor_q <= 1'b1;
            end else if (durum_q == TEMIZLE) begin
                temizle_bekliyor_q <= 1'b0;
            end
            if (durum_q == KARSILASTIR) begin
                if (isabet && (isabet_sayac_o != '1)) begin
                    isabet_sayac_o <= isabet_sayac_o + 1'b1;
                end
                if (!isabet && (iska_sayac_o != '1)) begin
                    iska_sayac_o <= iska_sayac_o + 1'b1;
                end
            end
        end
    end

    // Ready does not look at temizle_i directly: a request accepted in the
    // same cycle as the flush pulse is still serviced before the flush.
    always_comb begin
        getir_istek_hazir_o = 1'b0;
        if (!rst_i && !temizle_bekliyor_q) begin
            getir_istek_hazir_o = (durum_q == BOSTA) || ((durum_q == KARSILASTIR) && isabet);
        end
    end

    always_comb begin
        durum_d                         = durum_q;
        getir_buyruk_o                  = '0;
        getir_buyruk_gecerli_o          = 1'b0;
        anabellek_okuma_istek_gecerli_o = 1'b0;
        yazma                           = 1'b0;
        gecersizle                      = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (kabul) begin
                    durum_d = KARSILASTIR;
                end else if (temizle_bekliyor_q) begin
                    durum_d = TEMIZLE;
                end
            end
            KARSILASTIR: begin
                if (isabet) begin
                    getir_buyruk_o         = okuma_kelimeleri[kelime_sec];
                    getir_buyruk_gecerli_o = !rst_i;
                    durum_d                = kabul ? KARSILASTIR : BOSTA;
                end else begin
                    durum_d = ANABELLEK_ISTE;
                end
            end
            ANABELLEK_ISTE: begin
                anabellek_okuma_istek_gecerli_o = !rst_i;
                if (anabellek_okuma_istek_hazir_i) begin
                    durum_d = ANABELLEK_BEKLE;
                end
            end
            ANABELLEK_BEKLE: begin
                if (anabellek_okuma_veri_gecerli_i) begin
                    yazma   = 1'b1;
                    durum_d = CEVAPLA;
                end
            end
            CEVAPLA: begin
                getir_buyruk_o         = blok_kelimeleri[kelime_sec];
                getir_buyruk_gecerli_o = !rst_i;
                durum_d                = BOSTA;
            end
            TEMIZLE: begin
                gecersizle = 1'b1;
                durum_d    = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

endmodule

// File: tb/tb_buyruk_onbellek_denetleyici_p.sv
// tb/tb_buyruk_onbellek_denetleyici_p.sv - self-checking bench for the instruction cache controller
module tb_buyruk_onbellek_denetleyici_p;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  getir_istek_adres_i;
    logic         getir_istek_gecerli_i;
    logic         temizle_i;
    logic         ana_hazir;
    logic [127:0] ana_blok;
    logic         ana_veri_gecerli;

    logic         hazir, buyruk_gecerli, ana_gecerli;
    logic [31:0]  buyruk, ana_adres, isabet, iska;
    logic         s_hazir, s_buyruk_gecerli, s_ana_gecerli;
    logic [31:0]  s_buyruk, s_ana_adres;
    logic [1:0]   s_isabet, s_iska;

    always #5 clk_i = ~clk_i;

    buyruk_onbellek_denetleyici_p dut (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .getir_istek_adres_i             (getir_istek_adres_i),
        .getir_istek_gecerli_i           (getir_istek_gecerli_i),
        .getir_istek_hazir_o             (hazir),
        .getir_buyruk_o                  (buyruk),
        .getir_buyruk_gecerli_o          (buyruk_gecerli),
        .temizle_i                       (temizle_i),
        .anabellek_okuma_istek_adres_o   (ana_adres),
        .anabellek_okuma_istek_gecerli_o (ana_gecerli),
        .anabellek_okuma_istek_hazir_i   (ana_hazir),
        .anabellek_okuma_veri_blok_i     (ana_blok),
        .anabellek_okuma_veri_gecerli_i  (ana_veri_gecerli),
        .isabet_sayac_o                  (isabet),
        .iska_sayac_o                    (iska)
    );

    buyruk_onbellek_denetleyici_p #(.SAYAC_BIT(2)) dut_kucuk (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .getir_istek_adres_i             (getir_istek_adres_i),
        .getir_istek_gecerli_i           (getir_istek_gecerli_i),
        .getir_istek_hazir_o             (s_hazir),
        .getir_buyruk_o                  (s_buyruk),
        .getir_buyruk_gecerli_o          (s_buyruk_gecerli),
        .temizle_i                       (temizle_i),
        .anabellek_okuma_istek_adres_o   (s_ana_adres),
        .anabellek_okuma_istek_gecerli_o (s_ana_gecerli),
        .anabellek_okuma_istek_hazir_i   (ana_hazir),
        .anabellek_okuma_veri_blok_i     (ana_blok),
        .anabellek_okuma_veri_gecerli_i  (ana_veri_gecerli),
        .isabet_sayac_o                  (s_isabet),
        .iska_sayac_o                    (s_iska)
    );

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: observed %0h expected %0h", etiket, gozlenen, beklenen);
        end
    endtask

    // Memory image: word w of a line is (w+1)*0x11111111 + (line ^ 0x1000).
    function automatic logic [31:0] mem_kelime(input logic [31:0] a);
        logic [31:0] satir;
        logic [31:0] w;
        satir = a & 32'hFFFF_FFF0;
        w     = {30'd0, a[3:2]};
        return (w + 32'd1) * 32'h1111_1111 + (satir ^ 32'h0000_1000);
    endfunction

    function automatic logic [127:0] mem_blok(input logic [31:0] satir);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = mem_kelime(satir + 32'(w * 4));
        end
        return b;
    endfunction

    function automatic logic [1:0] doyur3(input int unsigned n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    // Reference model: which lines are resident, what responses are due and when.
    typedef struct {
        logic [31:0] veri;
        int          vade;
    } beklenen_t;

    bit          m_gecerli [256];
    logic [19:0] m_etiket  [256];
    int unsigned m_isabet, m_iska;
    beklenen_t   bq[$];
    logic [31:0] rq[$];
    bit          dolum_suruyor = 1'b0;
    int          el_sayisi = 0;
    logic [31:0] el_adres = '0;
    logic [31:0] son_veri = '0;
    logic [31:0] son_dolum = '0;
    int          darbe_sayisi = 0;
    bit          onceki_rst = 1'b1;
    int          cyc = 0;
    int          bayat_istek = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_i) begin
            kontrol("reset_hazir", hazir, 1'b0);
            for (int i = 0; i < 256; i++) m_gecerli[i] = 1'b0;
            m_isabet = 0;
            m_iska   = 0;
            bq.delete();
            rq.delete();
            dolum_suruyor = 1'b0;
            onceki_rst    = 1'b1;
        end else begin
            if (onceki_rst) begin
                kontrol("reset_sonrasi_hazir", hazir, 1'b1);
                kontrol("reset_isabet", isabet, 0);
                kontrol("reset_iska", iska, 0);
                kontrol("reset_ana_adres", ana_adres, 0);
                kontrol("reset_ana_gecerli", ana_gecerli, 1'b0);
                kontrol("reset_buyruk", {buyruk_gecerli, buyruk}, 0);
                onceki_rst = 1'b0;
            end
            if (bq.size() > 0 && bq[0].vade == cyc) begin
                kontrol("darbe_zamani", buyruk_gecerli, 1'b1);
                kontrol("buyruk", buyruk, bq[0].veri);
                son_veri = buyruk;
                if (buyruk_gecerli) darbe_sayisi++;
                void'(bq.pop_front());
            end else if (buyruk_gecerli) begin
                kontrol("beklenmeyen_darbe", buyruk_gecerli, 1'b0);
                darbe_sayisi++;
            end
            if (ana_veri_gecerli && dolum_suruyor) begin
                dolum_suruyor = 1'b0;
                if (bq.size() > 0) bq[0].vade = cyc + 1;
            end
            if (ana_gecerli && ana_hazir) begin
                son_dolum = ana_adres;
                if (rq.size() > 0) begin
                    el_adres = rq.pop_front();
                    kontrol("dolum_adresi", ana_adres, el_adres);
                end else begin
                    kontrol("beklenmeyen_dolum", ana_gecerli, 1'b0);
                    el_adres = ana_adres;
                end
                dolum_suruyor = 1'b1;
                el_sayisi++;
            end
            if (getir_istek_gecerli_i && hazir) begin
                int          idx;
                logic [19:0] etk;
                idx = int'(getir_istek_adres_i[11:4]);
                etk = getir_istek_adres_i[31:12];
                if (m_gecerli[idx] && m_etiket[idx] == etk) begin
                    m_isabet++;
                    bq.push_back('{mem_kelime(getir_istek_adres_i), cyc + 1});
                end else begin
                    m_iska++;
                    m_gecerli[idx] = 1'b1;
                    m_etiket[idx]  = etk;
                    rq.push_back(getir_istek_adres_i & 32'hFFFF_FFF0);
                    bq.push_back('{mem_kelime(getir_istek_adres_i), -1});
                end
            end
            if (temizle_i) begin
                for (int i = 0; i < 256; i++) m_gecerli[i] = 1'b0;
            end
        end
    end

    // Main-memory responder: random request stalls, 0..3 cycle return latency.
    initial begin
        int islenen    = 0;
        int bayat_yap  = 0;
        int gecikme    = 0;
        bit bekleyen   = 1'b0;
        logic [31:0] adr = '0;
        ana_hazir        = 1'b0;
        ana_veri_gecerli = 1'b0;
        ana_blok         = '0;
        forever begin
            @(posedge clk_i);
            #1;
            ana_hazir        = ($urandom_range(0, 3) != 0);
            ana_veri_gecerli = 1'b0;
            if (rst_i) begin
                bekleyen = 1'b0;
                islenen  = el_sayisi;
            end else begin
                if (el_sayisi != islenen) begin
                    islenen  = el_sayisi;
                    adr      = el_adres;
                    gecikme  = $urandom_range(0, 3);
                    bekleyen = 1'b1;
                end
                if (bekleyen) begin
                    if (gecikme == 0) begin
                        ana_veri_gecerli = 1'b1;
                        ana_blok         = mem_blok(adr);
                        bekleyen         = 1'b0;
                    end else begin
                        gecikme--;
                    end
                end else if (bayat_istek != bayat_yap) begin
                    bayat_yap        = bayat_istek;
                    ana_veri_gecerli = 1'b1;
                    ana_blok         = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic saat();
        @(posedge clk_i);
        #1;
    endtask

    task automatic iste(input logic [31:0] a, input bit tut);
        int n;
        n = 0;
        getir_istek_gecerli_i = 1'b1;
        getir_istek_adres_i   = a;
        forever begin
            @(negedge clk_i);
            if (hazir || n > 200) break;
            n++;
        end
        if (!hazir) kontrol("kabul_zaman_asimi", hazir, 1'b1);
        saat();
        if (!tut) getir_istek_gecerli_i = 1'b0;
    endtask

    task automatic bosta_bekle();
        int n;
        n = 0;
        while ((bq.size() != 0 || dolum_suruyor) && n < 300) begin
            saat();
            n++;
        end
        if (n >= 300) kontrol("bosta_zaman_asimi", bq.size(), 0);
        repeat (3) saat();
    endtask

    task automatic dolum_bekle();
        int n;
        n = 0;
        while (!dolum_suruyor && n < 100) begin
            saat();
            n++;
        end
        if (!dolum_suruyor) kontrol("dolum_zaman_asimi", dolum_suruyor, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        rst_i                 = 1'b1;
        getir_istek_gecerli_i = 1'b0;
        getir_istek_adres_i   = '0;
        temizle_i             = 1'b0;
        repeat (3) saat();
        rst_i = 1'b0;
        saat();

        // Cold miss
        iste(32'h0000_1004, 1'b0);
        bosta_bekle();
        kontrol("soguk_iska", iska, 1);
        kontrol("soguk_isabet", isabet, 0);
        kontrol("soguk_dolum_adresi", son_dolum, 32'h0000_1000);
        kontrol("soguk_veri", son_veri, 32'h2222_2222);

        // Back-to-back hits
        iste(32'h0000_1000, 1'b1);
        iste(32'h0000_1008, 1'b1);
        iste(32'h0000_100C, 1'b0);
        bosta_bekle();
        kontrol("ardisik_isabet", isabet, 3);
        kontrol("ardisik_son_veri", son_veri, 32'h4444_4444);

        // Conflict on index 0
        iste(32'h0000_2004, 1'b0);
        bosta_bekle();
        kontrol("cakisma_iska", iska, 2);
        kontrol("cakisma_dolum", son_dolum, 32'h0000_2000);
        iste(32'h0000_1004, 1'b0);
        bosta_bekle();
        kontrol("cakisma_geri_iska", iska, 3);

        // Flush during refill
        iste(32'h0000_2008, 1'b0);
        dolum_bekle();
        temizle_i = 1'b1;
        saat();
        temizle_i = 1'b0;
        n = 0;
        while (!buyruk_gecerli && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        kontrol("temizle_cevap", buyruk_gecerli, 1'b1);
        @(negedge clk_i);
        n = 0;
        while (!hazir && n < 10) begin
            n++;
            @(negedge clk_i);
        end
        kontrol("temizle_sure", n, 2);
        saat();
        iste(32'h0000_1000, 1'b0);
        bosta_bekle();
        kontrol("temizle_sonrasi_iska", iska, 5);

        // Reset mid-refill, then stale line return
        iste(32'h0000_3000, 1'b0);
        dolum_bekle();
        rst_i = 1'b1;
        saat();
        rst_i = 1'b0;
        d0 = darbe_sayisi;
        bayat_istek++;
        repeat (6) saat();
        kontrol("bayat_darbe", darbe_sayisi - d0, 0);
        kontrol("bayat_isabet", isabet, 0);
        kontrol("bayat_iska", iska, 0);
        iste(32'h0000_1000, 1'b0);
        bosta_bekle();
        kontrol("reset_sonrasi_iska", iska, 1);

        // Saturation on the 2-bit instance
        iste(32'h0000_1000, 1'b1);
        iste(32'h0000_1004, 1'b1);
        iste(32'h0000_1008, 1'b1);
        iste(32'h0000_100C, 1'b1);
        iste(32'h0000_1000, 1'b0);
        bosta_bekle();
        kontrol("doyma_isabet", isabet, 5);
        kontrol("doyma_kucuk_isabet", s_isabet, 2'd3);
        kontrol("doyma_kucuk_iska", s_iska, 2'd1);

        // Random traffic over a small colliding address pool
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) begin
                temizle_i = 1'b1;
                saat();
                temizle_i = 1'b0;
            end
            iste(a, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) begin
                getir_istek_gecerli_i = 1'b0;
                repeat ($urandom_range(1, 3)) saat();
            end
        end
        getir_istek_gecerli_i = 1'b0;
        bosta_bekle();
        kontrol("rastgele_isabet", isabet, m_isabet);
        kontrol("rastgele_iska", iska, m_iska);
        kontrol("rastgele_kucuk_isabet", s_isabet, doyur3(m_isabet));
        kontrol("rastgele_kucuk_iska", s_iska, doyur3(m_iska));

        $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
